// File: rtl/seven_segment_fun1.sv
// Single-digit seven-segment "fun" controller: four debounced buttons drive a hex
// counter or a rotating snake, with optional auto-advance and a decimal-point flag.
module seven_segment_fun1 #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int AUTO_PERIOD     = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(AUTO_PERIOD);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_PERIOD - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [3:0]    sync1_r;
   logic [3:0]    sync2_r;
   logic [3:0]    db_r;
   logic [3:0]    db_d_r;
   logic [CW-1:0] cnt_r [4];

   logic [3:0]    value_r;
   logic [2:0]    pos_r;
   logic          auto_en_r;
   logic          mode_r;
   logic [PW-1:0] pre_r;

   logic [3:0]    value_nxt_s;
   logic [2:0]    pos_nxt_s;
   logic          auto_nxt_s;
   logic          mode_nxt_s;
   logic [PW-1:0] pre_nxt_s;
   logic          step_up_s;
   logic          step_dn_s;
   logic [3:0]    press_s;
   logic          tick_s;
   logic [6:0]    seg_s;
   logic          unused_s;

   function automatic logic [6:0] digit_seg(input logic [3:0] v);
      case (v)
         4'h0:    digit_seg = 7'h3F;
         4'h1:    digit_seg = 7'h06;
         4'h2:    digit_seg = 7'h5B;
         4'h3:    digit_seg = 7'h4F;
         4'h4:    digit_seg = 7'h66;
         4'h5:    digit_seg = 7'h6D;
         4'h6:    digit_seg = 7'h7D;
         4'h7:    digit_seg = 7'h07;
         4'h8:    digit_seg = 7'h7F;
         4'h9:    digit_seg = 7'h6F;
         4'hA:    digit_seg = 7'h77;
         4'hB:    digit_seg = 7'h7C;
         4'hC:    digit_seg = 7'h39;
         4'hD:    digit_seg = 7'h5E;
         4'hE:    digit_seg = 7'h79;
         4'hF:    digit_seg = 7'h71;
         default: digit_seg = 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] snake_seg(input logic [2:0] p);
      case (p)
         3'd0:    snake_seg = 7'h01;
         3'd1:    snake_seg = 7'h02;
         3'd2:    snake_seg = 7'h04;
         3'd3:    snake_seg = 7'h08;
         3'd4:    snake_seg = 7'h10;
         3'd5:    snake_seg = 7'h20;
         default: snake_seg = 7'h00;
      endcase
   endfunction

   // Two-flop synchronizers, debounce counters and the delayed level for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
         db_r    <= 4'b0000;
         db_d_r  <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else begin
         sync1_r <= ui_in[3:0];
         sync2_r <= sync1_r;
         db_d_r  <= db_r;
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] == DB_LAST) begin
               db_r[i]  <= sync2_r[i];
               cnt_r[i] <= {CW{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   assign press_s = db_r & ~db_d_r;
   assign tick_s  = auto_en_r && (pre_r == PRE_LAST);

   // Prioritised action select and next-state computation
   always_comb begin
      value_nxt_s = value_r;
      pos_nxt_s   = pos_r;
      auto_nxt_s  = auto_en_r;
      mode_nxt_s  = mode_r;
      pre_nxt_s   = pre_r;
      step_up_s   = 1'b0;
      step_dn_s   = 1'b0;
      if (ena) begin
         if (press_s[3]) begin
            mode_nxt_s = ~mode_r;
         end else if (press_s[2]) begin
            auto_nxt_s = ~auto_en_r;
         end else if (press_s[0]) begin
            step_up_s = 1'b1;
         end else if (press_s[1]) begin
            step_dn_s = 1'b1;
         end else if (tick_s) begin
            step_up_s = 1'b1;
         end else begin
            step_up_s = 1'b0;
         end

         // A btn3 action restarts the period; the prescaler otherwise runs only in auto mode
         if (press_s[2] && !press_s[3]) begin
            pre_nxt_s = {PW{1'b0}};
         end else if (!auto_en_r) begin
            pre_nxt_s = {PW{1'b0}};
         end else if (pre_r == PRE_LAST) begin
            pre_nxt_s = {PW{1'b0}};
         end else begin
            pre_nxt_s = pre_r + PRE_ONE;
         end

         if (step_up_s) begin
            if (mode_r) begin
               pos_nxt_s = (pos_r == 3'd5) ? 3'd0 : pos_r + 3'd1;
            end else begin
               value_nxt_s = value_r + 4'd1;
            end
         end else if (step_dn_s) begin
            if (mode_r) begin
               pos_nxt_s = (pos_r == 3'd0) ? 3'd5 : pos_r - 3'd1;
            end else begin
               value_nxt_s = value_r - 4'd1;
            end
         end else begin
            value_nxt_s = value_r;
         end
      end else begin
         pre_nxt_s = pre_r;
      end
   end

   // Display state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r   <= 4'd0;
         pos_r     <= 3'd0;
         auto_en_r <= 1'b0;
         mode_r    <= 1'b0;
         pre_r     <= {PW{1'b0}};
      end else begin
         value_r   <= value_nxt_s;
         pos_r     <= pos_nxt_s;
         auto_en_r <= auto_nxt_s;
         mode_r    <= mode_nxt_s;
         pre_r     <= pre_nxt_s;
      end
   end

   // Segment decode from registered state
   always_comb begin
      if (mode_r) begin
         seg_s = snake_seg(pos_r);
      end else begin
         seg_s = digit_seg(value_r);
      end
   end

   assign uo_out   = {auto_en_r, seg_s};
   assign uio_out  = 8'h00;
   assign uio_oe   = 8'h00;
   assign unused_s = ^{uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_seven_segment_fun1.sv
// Self-checking bench for seven_segment_fun1: directed scenarios plus random button
// activity, compared every cycle against a behavioural model of the display rules.
module tb_seven_segment_fun1;

   localparam int DB = 4;
   localparam int AP = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   seven_segment_fun1 #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   int m_value, m_pos, m_pre, m_auto, m_mode;
   int m_db[4], m_db_prev[4], m_run[4], m_h1[4], m_h2[4];

   logic [6:0] digit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic advance(input int dir);
      if (m_mode != 0) m_pos = (m_pos + dir + 6) % 6;
      else             m_value = (m_value + dir + 16) % 16;
   endtask

   task automatic model_step();
      int pr[4];
      int tick;
      int old_auto;
      if (rst) begin
         m_value = 0; m_pos = 0; m_pre = 0; m_auto = 0; m_mode = 0;
         for (int b = 0; b < 4; b++) begin
            m_db[b] = 0; m_db_prev[b] = 0; m_run[b] = 0; m_h1[b] = 0; m_h2[b] = 0;
         end
      end else begin
         for (int b = 0; b < 4; b++) pr[b] = (m_db[b] == 1 && m_db_prev[b] == 0) ? 1 : 0;
         tick = (m_auto == 1 && m_pre == AP - 1) ? 1 : 0;
         old_auto = m_auto;
         if (ena) begin
            if (pr[3] == 1)      m_mode = 1 - m_mode;
            else if (pr[2] == 1) m_auto = 1 - m_auto;
            else if (pr[0] == 1) advance(1);
            else if (pr[1] == 1) advance(-1);
            else if (tick == 1)  advance(1);
            if (pr[2] == 1 && pr[3] == 0) m_pre = 0;
            else if (old_auto == 0)       m_pre = 0;
            else                          m_pre = (m_pre + 1) % AP;
         end
         // a level is accepted after DB consecutive synchronized samples that differ from it
         for (int b = 0; b < 4; b++) begin
            m_db_prev[b] = m_db[b];
            if (m_h2[b] != m_db[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_db[b] = m_h2[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
            m_h2[b] = m_h1[b];
            m_h1[b] = int'(ui_in[b]);
         end
      end
   endtask

   function automatic logic [7:0] model_out();
      logic [7:0] e;
      e[6:0] = (m_mode != 0) ? 7'(7'd1 << m_pos) : digit_tab[m_value];
      e[7]   = (m_auto != 0);
      return e;
   endfunction

   // One clock: advance the model at the edge, compare on the falling edge
   task automatic cycle();
      logic [7:0] e;
      @(posedge clk);
      model_step();
      @(negedge clk);
      e = model_out();
      checks++;
      if (uo_out !== e) begin
         errors++;
         $display("FAIL uo_out t=%0t got %h want %h", $time, uo_out, e);
      end
      checks++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
         errors++;
         $display("FAIL uio t=%0t got out=%h oe=%h want 00/00", $time, uio_out, uio_oe);
      end
   endtask

   task automatic lit(input string nm, input logic [7:0] want);
      checks++;
      if (uo_out !== want) begin
         errors++;
         $display("FAIL %s dut got %h want %h", nm, uo_out, want);
      end
      checks++;
      if (model_out() !== want) begin
         errors++;
         $display("FAIL %s model got %h want %h", nm, model_out(), want);
      end
   endtask

   task automatic press(input logic [3:0] mask, input int hold, input int idle);
      ui_in = {4'b0000, mask};
      repeat (hold) cycle();
      ui_in = 8'h00;
      repeat (idle) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   logic [7:0] exp_up [3]  = '{8'h06, 8'h5B, 8'h4F};
   logic [7:0] exp_dn [4]  = '{8'h5B, 8'h06, 8'h3F, 8'h71};
   logic [7:0] exp_sn [6]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
   logic [3:0] btn_lvl;

   initial begin
      rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
      do_reset();
      repeat (10) cycle();
      lit("reset_idle", 8'h3F);

      // single-cycle bounce on btn1
      for (int i = 0; i < 8; i++) begin
         ui_in = (i % 2 == 0) ? 8'h01 : 8'h00;
         cycle();
      end
      ui_in = 8'h00;
      repeat (8) cycle();
      lit("bounce", 8'h3F);

      for (int i = 0; i < 3; i++) begin
         press(4'b0001, 10, 8);
         lit("btn1_up", exp_up[i]);
      end
      for (int i = 0; i < 4; i++) begin
         press(4'b0010, 10, 8);
         lit("btn2_dn", exp_dn[i]);
      end

      press(4'b1000, 10, 8);
      lit("mode_snake", 8'h01);
      for (int i = 0; i < 6; i++) begin
         press(4'b0001, 10, 8);
         lit("snake_up", exp_sn[i]);
      end
      press(4'b0010, 10, 8);
      lit("snake_dn_wrap", 8'h20);

      // auto-advance in DIGIT mode, through a full wrap
      do_reset();
      press(4'b0100, 10, 2);
      checks++;
      if (uo_out[7] !== 1'b1) begin
         errors++;
         $display("FAIL auto_on dp got %b want 1", uo_out[7]);
      end
      repeat (140) cycle();
      press(4'b0100, 10, 8);
      checks++;
      if (uo_out[7] !== 1'b0) begin
         errors++;
         $display("FAIL auto_off dp got %b want 0", uo_out[7]);
      end
      repeat (20) cycle();

      // btn1 and btn4 together: only the mode toggle
      do_reset();
      press(4'b1001, 10, 8);
      lit("btn4_over_btn1", 8'h01);

      // reset mid-count
      ui_in = 8'h01;
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      lit("mid_reset", 8'h3F);
      rst = 1'b0;
      ui_in = 8'h00;
      repeat (10) cycle();

      // randomized button activity with ena gaps and occasional resets
      btn_lvl = 4'b0000;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) btn_lvl[$urandom_range(0, 3)] ^= 1'b1;
         ui_in  = {4'($urandom_range(0, 15)), btn_lvl};
         uio_in = 8'($urandom_range(0, 255));
         ena    = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 699) == 0);
         cycle();
      end
      rst = 1'b0;
      ena = 1'b1;
      ui_in = 8'h00;
      repeat (10) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
